// File: rtl/mudv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, move-to
// write enables and result-select codes used by the decoder and mudv.
package mudv_pkg;

    localparam logic [2:0] MUDVOP_MULT  = 3'b000;
    localparam logic [2:0] MUDVOP_MULTU = 3'b001;
    localparam logic [2:0] MUDVOP_DIV   = 3'b010;
    localparam logic [2:0] MUDVOP_DIVU  = 3'b011;

    localparam logic [1:0] MUDVWEN_HI = 2'b10;
    localparam logic [1:0] MUDVWEN_LO = 2'b01;

    localparam logic [1:0] RESSRC_HI = 2'b10;
    localparam logic [1:0] RESSRC_LO = 2'b01;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mudv_calc.sv
// Combinational 64-bit {HI, LO} generator for mult/multu/div/divu, plus the
// divide-by-zero flag that suppresses the commit.
module mudv_calc
    import mudv_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        dz
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    assign sa64 = {{32{a[31]}}, a};
    assign sb64 = {{32{b[31]}}, b};
    assign sa   = a;
    assign sb   = b;

    always_comb begin
        res = '0;
        sq  = '0;
        sr  = '0;
        dz  = (b == 32'h0);
        unique case ({1'b0, op})
            MUDVOP_MULT:  res = sa64 * sb64;
            MUDVOP_MULTU: res = {32'h0, a} * {32'h0, b};
            MUDVOP_DIV: begin
                // The one signed quotient that does not fit in 32 bits wraps.
                if (dz) begin
                    res = '0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr, sq};
                end
            end
            MUDVOP_DIVU: begin
                if (!dz) res = {a % b, a / b};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mudv.sv
// Multiply/divide unit with architectural HI/LO: stages the result at launch,
// counts a fixed latency, then commits; also serves mthi/mtlo and mfhi/mflo.
module mudv
    import mudv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MUDVstart,
    input  logic [2:0]  MUDVop,
    input  logic [1:0]  MUDVwen,
    input  logic [1:0]  ressrc,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] res
);

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      stg_hi_p0;
    logic [31:0]      stg_lo_p0;
    logic             stg_dz_p0;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      calc_res;
    logic             calc_dz;
    logic             launch;

    mudv_calc u_calc (
        .op  (MUDVop[1:0]),
        .a   (A),
        .b   (B),
        .res (calc_res),
        .dz  (calc_dz)
    );

    assign launch = MUDVstart && !busy && !MUDVop[2];
    assign stall  = busy | MUDVstart;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            stg_hi_p0 <= '0;
            stg_lo_p0 <= '0;
            stg_dz_p0 <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (!stg_dz_p0) begin
                    hi <= stg_hi_p0;
                    lo <= stg_lo_p0;
                end
            end
        end else if (launch) begin
            // Stage boundary: result captured here, committed when cnt hits 1.
            stg_hi_p0 <= calc_res[63:32];
            stg_lo_p0 <= calc_res[31:0];
            stg_dz_p0 <= calc_dz && op_is_div(MUDVop);
            cnt       <= op_is_div(MUDVop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy      <= 1'b1;
        end else if (!MUDVstart) begin
            // A start, even a reserved one, takes priority and drops the write.
            if (MUDVwen == MUDVWEN_HI) hi <= A;
            if (MUDVwen == MUDVWEN_LO) lo <= A;
        end
    end

    always_comb begin
        res = '0;
        if (ressrc == RESSRC_HI)      res = hi;
        else if (ressrc == RESSRC_LO) res = lo;
    end

endmodule
